// File: rtl/refresh_issuer.sv
// refresh_issuer: paces DRAM refreshes on a tREFI timer. Every refresh first
// asks the segment-peak tracker whether the current row can be skipped. A
// skipped refresh completes as a dummy. Otherwise a refresh command is handed
// to the scheduler with a valid/ready handshake. Refreshes that are owed but
// not yet done are counted in pend_cnt, which is limited to MAX_PEND.
module refresh_issuer #(
  parameter int ROW_WIDTH = 16,
  parameter int T_REFI    = 7800,
  parameter int MAX_PEND  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 to_refresh,
  input  logic                 dref,
  output logic                 ref_req_valid,
  input  logic                 ref_req_ready,
  output logic [ROW_WIDTH-1:0] ref_req_row,
  output logic [3:0]           pend_cnt,
  output logic [15:0]          skip_cnt,
  output logic                 ovf_err
);

  localparam int TW = $clog2(T_REFI);

  typedef enum logic [1:0] {
    IDLE,
    QUERY,
    WAIT_DREF,
    ISSUE
  } state_t;

  state_t               state, state_next;
  logic [TW-1:0]        timer;
  logic [ROW_WIDTH-1:0] row;
  logic                 tick;
  logic                 dummy_done;
  logic                 issue_done;
  logic                 done;

  assign tick       = (timer == TW'(T_REFI - 1));
  assign dummy_done = (state == WAIT_DREF) && dref;
  assign issue_done = (state == ISSUE) && ref_req_valid && ref_req_ready;
  assign done       = dummy_done || issue_done;

  // The row counter is already registered and changes only when a refresh
  // completes, so it stays stable for as long as a request is pending.
  assign ref_req_row = row;

  // Free-running interval timer that wraps after T_REFI-1.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked block uses non-blocking assignments. Each flop then
    // samples the values from before the edge, whatever order the blocks run in.
    if (rst) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Owed-refresh bookkeeping. A tick and a completion in the same cycle
  // cancel out, and that tick does not count as an overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= 4'd0;
      ovf_err  <= 1'b0;
    end else if (tick && !done) begin
      if (pend_cnt == 4'(MAX_PEND)) begin
        ovf_err <= 1'b1;
      end else begin
        pend_cnt <= pend_cnt + 4'd1;
      end
    end else if (done && !tick) begin
      pend_cnt <= pend_cnt - 4'd1;
    end
  end

  // Row pointer and the saturating dummy-refresh counter move on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      skip_cnt <= 16'd0;
    end else begin
      if (done) begin
        row <= row + ROW_WIDTH'(1);
      end
      if (dummy_done && (skip_cnt != 16'hFFFF)) begin
        skip_cnt <= skip_cnt + 16'd1;
      end
    end
  end

  // State register. The two strobes are registered copies of the next state,
  // so they can never be high in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      to_refresh    <= 1'b0;
      ref_req_valid <= 1'b0;
    end else begin
      state         <= state_next;
      to_refresh    <= (state_next == QUERY);
      ref_req_valid <= (state_next == ISSUE);
    end
  end

  // Next-state logic. A query, then the tracker verdict, then an optional
  // handshake that is held until the scheduler accepts the request.
  always_comb begin
    // NOTE: the default is assigned first, so no path through the case
    // leaves state_next unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:      if (pend_cnt != 4'd0) state_next = QUERY;
      QUERY:     state_next = WAIT_DREF;
      WAIT_DREF: state_next = dref ? IDLE : ISSUE;
      ISSUE:     if (ref_req_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

endmodule

// File: doc/refresh_issuer.md
REFRESH_ISSUER -- requirements
Module: refresh_issuer

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 16, meaning row address width (rows = 2^ROW_WIDTH).
REQ-002 SHALL have parameter T_REFI, default 7800, meaning refresh interval in clk cycles (>= 4).
REQ-003 SHALL have parameter MAX_PEND, default 8, meaning maximum owed (postponed) refreshes (1..15).
REQ-004 SHALL have port clk, input, 1, meaning the only clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port to_refresh, output, 1, meaning single-cycle query pulse to the segment-peak tracker for the current row.
REQ-007 SHALL have port dref, input, 1, meaning tracker verdict (1 = dummy/skip, 0 = real refresh), valid exactly 1 cycle after to_refresh.
REQ-008 SHALL have port ref_req_valid, output, 1, meaning refresh command request to the DRAM command scheduler.
REQ-009 SHALL have port ref_req_ready, input, 1, meaning the command scheduler accepts the request.
REQ-010 SHALL have port ref_req_row, output, ROW_WIDTH, meaning the row to refresh; stable while ref_req_valid=1.
REQ-011 SHALL have port pend_cnt, output, 4, meaning current owed refresh count.
REQ-012 SHALL have port skip_cnt, output, 16, meaning saturating count of dummy (skipped) refreshes.
REQ-013 SHALL have port ovf_err, output, 1, meaning sticky flag: a tREFI tick arrived while pend_cnt = MAX_PEND.

Function
REQ-014 SHALL run a free-running interval timer counting 0..T_REFI-1 and wrapping; a tick occurs in the cycle the timer equals T_REFI-1.
REQ-015 SHALL increment pend_cnt on each tick unless pend_cnt = MAX_PEND, in which case pend_cnt holds and ovf_err sets to 1.
REQ-016 SHALL decrement pend_cnt by 1 on each completed refresh (dummy resolution or ref_req_valid & ref_req_ready); tick plus completion in the same cycle leaves pend_cnt unchanged and sets no ovf_err.
REQ-017 SHALL implement FSM states IDLE, QUERY, WAIT_DREF, ISSUE.
REQ-018 IDLE SHALL go to QUERY on the next edge when pend_cnt > 0; otherwise stay.
REQ-019 QUERY SHALL assert to_refresh for exactly one cycle, then go to WAIT_DREF.
REQ-020 WAIT_DREF SHALL sample dref; dref=1 -> complete as dummy (row++, skip_cnt++ saturating at 16'hFFFF, pend_cnt--), go to IDLE; dref=0 -> go to ISSUE.
REQ-021 ISSUE SHALL hold ref_req_valid=1 and ref_req_row constant until ref_req_ready=1; on the accepting cycle complete (row++, pend_cnt--), and go to IDLE with ref_req_valid=0 next cycle.
REQ-022 ref_req_valid SHALL never deassert without acceptance; ref_req_ready while not valid SHALL be ignored.
REQ-023 Row counter SHALL be ROW_WIDTH bits, wrap 2^ROW_WIDTH-1 -> 0, and advance only on completion.
REQ-024 Minimum query-to-next-query spacing SHALL be 3 cycles (IDLE, QUERY, WAIT_DREF); dref outside WAIT_DREF SHALL be ignored.
REQ-025 to_refresh and ref_req_valid SHALL be registered outputs, never asserted in the same cycle.

Reset
REQ-026 rst=1 SHALL immediately force FSM=IDLE, timer=0, row=0, pend_cnt=0, skip_cnt=0, ovf_err=0, to_refresh=0, ref_req_valid=0, ref_req_row=0.
REQ-027 Reset asserted mid-ISSUE or mid-WAIT_DREF SHALL abandon the operation without completion; the first tick after release occurs T_REFI cycles after release.
REQ-028 ovf_err SHALL clear only on reset.

Verification (T_REFI=16, MAX_PEND=8, ROW_WIDTH=4 unless noted)
REQ-029 Release rst, dref=0, ready=1 always -> first to_refresh at cycle 17, ref_req_valid with row 0 at cycle 19, row 1 issued 16 cycles later; pend_cnt peaks at 1.
REQ-030 dref=1 for every query -> ref_req_valid never asserts, skip_cnt = 5 after 5 ticks, row = 5, pend_cnt returns to 0.
REQ-031 ready=0 for 200 cycles -> ref_req_row held at 0, pend_cnt saturates at 8 at the 8th tick, ovf_err=1 at the 9th tick, stays 1 after ready=1 resumes drain.
REQ-032 Tick coincident with ISSUE acceptance at pend_cnt=3 -> pend_cnt stays 3, ovf_err stays 0.
REQ-033 17 real refreshes -> ref_req_row sequence 0..15 then 0 (wrap).
REQ-034 rst pulse while ref_req_valid=1 -> ref_req_valid=0 same cycle, row=0, pend_cnt=0, next to_refresh 17 cycles after release.
